mem_port_arbiter: RTL

- Shares one single-ported unified RAM between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline.
- Serialises accesses with a fixed-latency handshake toward the RAM.
- Generates the stall signals that freeze the PC, IFID, IDEX, EXMEM and MEMWB while an access is outstanding.
- MEM-stage requests have priority over fetch, because they belong to the older instruction.

---
 rtl/mem_port_arbiter_if.sv | 52 +++++
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between mem_port_arbiter, the IF/MEM pipeline stages and the unified RAM.
// Defining MEM_ARB_PERF_EN adds the if_conflict_cnt_o / mem_acc_cnt_o counter outputs.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_ready_o;
    logic              mem_req_i;
    logic              mem_we_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [DATA_W-1:0] mem_wdata_i;
    logic [DATA_W-1:0] mem_rdata_o;
    logic              mem_ready_o;
    logic              ram_en_o;
    logic              ram_we_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [DATA_W-1:0] ram_wdata_o;
    logic [DATA_W-1:0] ram_rdata_i;
    logic              stall_if_o;
    logic              stall_pipe_o;
`ifdef MEM_ARB_PERF_EN
    logic [31:0]       if_conflict_cnt_o;
    logic [31:0]       mem_acc_cnt_o;

    modport slave (
        input  if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, ram_rdata_i,
        output if_rdata_o, if_ready_o, mem_rdata_o, mem_ready_o,
        output ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, stall_if_o, stall_pipe_o,
        output if_conflict_cnt_o, mem_acc_cnt_o
    );
    modport master (
        output if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, ram_rdata_i,
        input  if_rdata_o, if_ready_o, mem_rdata_o, mem_ready_o,
        input  ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, stall_if_o, stall_pipe_o,
        input  if_conflict_cnt_o, mem_acc_cnt_o
    );
`else
    modport slave (
        input  if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, ram_rdata_i,
        output if_rdata_o, if_ready_o, mem_rdata_o, mem_ready_o,
        output ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, stall_if_o, stall_pipe_o
    );
    modport master (
        output if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, ram_rdata_i,
        input  if_rdata_o, if_ready_o, mem_rdata_o, mem_ready_o,
        input  ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, stall_if_o, stall_pipe_o
    );
`endif
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified RAM between fetch (IF) and load/store (MEM), MEM first,
// and produces pipeline stalls. Optional counters are enabled by defining MEM_ARB_PERF_EN.
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
) (
    input logic               clk_i,
    input logic               rst_i,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned      CNT_W    = 4;
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;   // 1 = MEM stage owns the access
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              if_ready_q, if_ready_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              mem_ready_q, mem_ready_d;
    logic              if_eff_c, mem_eff_c;

    // A request is not re-served in the cycle its own completion pulse is visible.
    assign if_eff_c  = bus.if_req_i  & ~if_ready_q;
    assign mem_eff_c = bus.mem_req_i & ~mem_ready_q;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        ram_en_d    = 1'b0;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if_rdata_d  = if_rdata_q;
        if_ready_d  = 1'b0;
        mem_rdata_d = mem_rdata_q;
        mem_ready_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_eff_c) begin
                    owner_d     = 1'b1;
                    ram_we_d    = bus.mem_we_i;
                    ram_addr_d  = bus.mem_addr_i;
                    ram_wdata_d = bus.mem_wdata_i;
                    ram_en_d    = 1'b1;
                    cnt_d       = LAT_LOAD;
                    state_d     = ST_ISSUE;
                end else if (if_eff_c) begin
                    owner_d     = 1'b0;
                    ram_we_d    = 1'b0;
                    ram_addr_d  = bus.if_addr_i;
                    ram_en_d    = 1'b1;
                    cnt_d       = LAT_LOAD;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                // Last WAIT cycle is the one where the RAM presents read data.
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    if (owner_q) begin
                        mem_ready_d = 1'b1;
                        if (!ram_we_q) mem_rdata_d = bus.ram_rdata_i;
                    end else begin
                        if_ready_d = 1'b1;
                        if_rdata_d = bus.ram_rdata_i;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            cnt_q       <= '0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            mem_rdata_q <= '0;
            mem_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            if_rdata_q  <= if_rdata_d;
            if_ready_q  <= if_ready_d;
            mem_rdata_q <= mem_rdata_d;
            mem_ready_q <= mem_ready_d;
        end
    end

    assign bus.ram_en_o     = ram_en_q;
    assign bus.ram_we_o     = ram_we_q;
    assign bus.ram_addr_o   = ram_addr_q;
    assign bus.ram_wdata_o  = ram_wdata_q;
    assign bus.if_rdata_o   = if_rdata_q;
    assign bus.if_ready_o   = if_ready_q;
    assign bus.mem_rdata_o  = mem_rdata_q;
    assign bus.mem_ready_o  = mem_ready_q;
    assign bus.stall_pipe_o = bus.mem_req_i & ~mem_ready_q;
    assign bus.stall_if_o   = (bus.if_req_i & ~if_ready_q) | (bus.mem_req_i & ~mem_ready_q);

`ifdef MEM_ARB_PERF_EN
    logic [31:0] conf_cnt_q, conf_cnt_d;
    logic [31:0] acc_cnt_q, acc_cnt_d;
    logic        conf_hit_c;

    // Fetch is blocked by a MEM access either in flight or winning arbitration now.
    assign conf_hit_c = if_eff_c & (((state_q != ST_IDLE) & owner_q) | ((state_q == ST_IDLE) & mem_eff_c));

    always_comb begin
        conf_cnt_d = conf_cnt_q;
        acc_cnt_d  = acc_cnt_q;
        if (conf_hit_c && (conf_cnt_q != 32'hFFFF_FFFF)) conf_cnt_d = conf_cnt_q + 32'd1;
        if (mem_ready_q && (acc_cnt_q != 32'hFFFF_FFFF)) acc_cnt_d = acc_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            conf_cnt_q <= '0;
            acc_cnt_q  <= '0;
        end else begin
            conf_cnt_q <= conf_cnt_d;
            acc_cnt_q  <= acc_cnt_d;
        end
    end

    assign bus.if_conflict_cnt_o = conf_cnt_q;
    assign bus.mem_acc_cnt_o     = acc_cnt_q;
`endif
endmodule
